coklu_sirali_kilit: RTL and testbench
=====================================

Name: coklu_sirali_kilit

Overview:
Parametrised, clocked successor to the dual combination-lock checker. Instead of comparing all right/left steps in parallel, it accepts steps one at a time over a valid-strobe interface and checks them against KILIT_SAYISI stored combinations in order. It also provides:
- an inactivity timeout;
- a consecutive-failure counter;
- a timed lockout after repeated wrong attempts.

It sits between the step-entry front end (debounced keypad/encoder) and the door actuator logic.

Parameters:
KILIT_SAYISI, 2, number of chained locks; each lock takes one right step then one left step.
DEGER_GEN, 3, width of one step value.
HATA_LIMIT, 3, consecutive failed attempts that trigger lockout (>=1).
KILITLEME_SURE, 8, lockout length in clock cycles (>=1).
ZAMAN_ASIMI, 16, idle cycles allowed between steps inside an attempt (>=2).

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
adim_gecerli  input  1  step strobe; one step accepted per cycle while high.
adim_yon  input  1  step direction: 0 = sag (right), 1 = sol (left).
adim_deger  input  DEGER_GEN  step value.
kilit_sifreler  input  2*KILIT_SAYISI*DEGER_GEN  combinations; lock i occupies slice [2*i*DEGER_GEN +: 2*DEGER_GEN] = {sag, sol}.
kilitle  input  1  re-lock request; pulse.
kilitler_acik  output  1  all locks open (level).
hata  output  1  one-cycle pulse on each failed attempt.
kilitli  output  1  lockout active.
hata_sayisi  output  $clog2(HATA_LIMIT+1)  consecutive failure count.
adim_sayaci  output  $clog2(2*KILIT_SAYISI+1)  steps accepted in the current attempt.

Behaviour:
- Reset (async, rst_n=0): state BOSTA; kilitler_acik=0, hata=0, kilitli=0, hata_sayisi=0, adim_sayaci=0. Internal mismatch flag, idle counter and lockout counter are cleared. Reset mid-attempt or mid-lockout discards everything.
- Expected step sequence: step 2k is lock k sag (yon=0); step 2k+1 is lock k sol (yon=1), k = 0..KILIT_SAYISI-1.
- kilit_sifreler is sampled into an internal register on the edge that accepts step 0. Later changes do not affect the attempt in progress.
- Step outcome: a step is wrong if its direction or its value differs from the expected one; either sets a sticky mismatch flag. There is no early abort: the block always consumes all 2*KILIT_SAYISI steps before reporting, so the failure position is not revealed.
- States:
  - BOSTA: idle. An accepted step goes to GIRIS with adim_sayaci=1.
  - GIRIS: each accepted step increments adim_sayaci and clears the idle counter. On the edge accepting the final step, evaluation is registered and visible the next cycle:
    - pass: go to ACIK, kilitler_acik=1, hata_sayisi=0.
    - fail: hata=1 for exactly one cycle, hata_sayisi+1. Go to KILITLI if the new count equals HATA_LIMIT, else BOSTA.
    - In both cases adim_sayaci returns to 0.
  - GIRIS with no step: the idle counter increments each cycle. When it reaches ZAMAN_ASIMI, the attempt is a failure, handled as above (hata pulse, count, possible lockout).
  - ACIK: kilitler_acik held at 1; steps ignored. kilitle=1 goes to BOSTA with kilitler_acik=0 the next cycle. If kilitle and adim_gecerli are both high, kilitle wins and the step is dropped.
  - KILITLI: kilitli=1 for exactly KILITLEME_SURE cycles, with steps and kilitle ignored. On exit: go to BOSTA, kilitli=0, hata_sayisi=0.
- kilitle in BOSTA, GIRIS or KILITLI has no effect.
- hata_sayisi never exceeds HATA_LIMIT; a success in ACIK clears it.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
Defaults used throughout; kilit_sifreler = 12'h7AA, i.e. lock0 sag=5, sol=2; lock1 sag=3, sol=6.
1. Reset, then steps (0,5),(1,2),(0,3),(1,6) on consecutive cycles -> kilitler_acik=1 starting the cycle after the 4th step; hata never pulses; adim_sayaci reads 1,2,3,4 and then 0.
2. Open state, then kilitle pulse together with adim_gecerli=1 -> kilitler_acik=0 the next cycle, state BOSTA, adim_sayaci=0.
3. Steps (0,5),(1,3),(0,3),(1,6) -> no reaction until the 4th step, then one hata pulse, hata_sayisi=1, kilitler_acik stays 0. Repeat the same attempt with (0,5) given as yon=1 -> hata_sayisi=2.
4. Three consecutive failures -> kilitli=1 for exactly 8 cycles; steps given during lockout are ignored (adim_sayaci stays 0). Then kilitli=0, hata_sayisi=0, and the correct sequence opens the lock.
5. One step (0,5), then 16 idle cycles -> hata pulse on timeout, hata_sayisi=1, state BOSTA. A step arriving at idle cycle 15 restarts the idle count with no failure.
6. Assert rst_n=0 mid-lockout and again mid-attempt -> all outputs return to 0 immediately (asynchronously); the next correct sequence opens the lock.

Source files
------------

// File: rtl/coklu_sirali_kilit.sv
// Sequential multi-lock combination checker: steps arrive one per strobe and are
// compared against KILIT_SAYISI stored {sag, sol} pairs, with timeout, failure count and lockout.
module coklu_sirali_kilit #(
    parameter int KILIT_SAYISI   = 2,
    parameter int DEGER_GEN      = 3,
    parameter int HATA_LIMIT     = 3,
    parameter int KILITLEME_SURE = 8,
    parameter int ZAMAN_ASIMI    = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    adim_gecerli,
    input  logic                                    adim_yon,
    input  logic [DEGER_GEN-1:0]                    adim_deger,
    input  logic [2*KILIT_SAYISI*DEGER_GEN-1:0]     kilit_sifreler,
    input  logic                                    kilitle,
    output logic                                    kilitler_acik,
    output logic                                    hata,
    output logic                                    kilitli,
    output logic [$clog2(HATA_LIMIT+1)-1:0]         hata_sayisi,
    output logic [$clog2(2*KILIT_SAYISI+1)-1:0]     adim_sayaci
);

    localparam int SIFRE_W = 2 * KILIT_SAYISI * DEGER_GEN;
    localparam int ADIM_W  = $clog2(2 * KILIT_SAYISI + 1);
    localparam int HS_W    = $clog2(HATA_LIMIT + 1);
    localparam int BOS_W   = $clog2(ZAMAN_ASIMI + 1);
    localparam int KS_W    = $clog2(KILITLEME_SURE + 1);

    localparam logic [ADIM_W-1:0] SON_ADIM = ADIM_W'(2 * KILIT_SAYISI - 1);
    localparam logic [BOS_W-1:0]  BOS_SON  = BOS_W'(ZAMAN_ASIMI - 1);
    localparam logic [KS_W-1:0]   KS_SON   = KS_W'(KILITLEME_SURE - 1);
    localparam logic [HS_W-1:0]   HS_LIM   = HS_W'(HATA_LIMIT);

    typedef enum logic [1:0] {
        BOSTA,
        GIRIS,
        ACIK,
        KILITLI
    } durum_t;

    durum_t               state_q, state_d;
    logic [ADIM_W-1:0]    adim_q, adim_d;
    logic                 mis_q, mis_d;
    logic [BOS_W-1:0]     bos_q, bos_d;
    logic [KS_W-1:0]      kcnt_q, kcnt_d;
    logic [HS_W-1:0]      hs_q, hs_d;
    logic                 acik_q, acik_d;
    logic                 hata_q, hata_d;
    logic                 kilitli_q, kilitli_d;
    logic [SIFRE_W-1:0]   sifre_q, sifre_d;

    logic                 deneme_bitti;
    logic                 basarisiz;
    logic [HS_W-1:0]      yeni_hs;

    // Step s belongs to lock s/2; sag sits in the upper half of the pair, so its slot is s^1.
    function automatic logic adim_hatali(input logic [SIFRE_W-1:0]   sifre,
                                         input logic [ADIM_W-1:0]    idx,
                                         input logic                 yon,
                                         input logic [DEGER_GEN-1:0] deger);
        int                   ofs;
        logic [DEGER_GEN-1:0] beklenen;
        ofs      = (int'(idx) ^ 1) * DEGER_GEN;
        beklenen = sifre[ofs +: DEGER_GEN];
        return (yon != idx[0]) || (deger != beklenen);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOSTA;
            adim_q    <= '0;
            mis_q     <= 1'b0;
            bos_q     <= '0;
            kcnt_q    <= '0;
            hs_q      <= '0;
            acik_q    <= 1'b0;
            hata_q    <= 1'b0;
            kilitli_q <= 1'b0;
            sifre_q   <= '0;
        end else begin
            state_q   <= state_d;
            adim_q    <= adim_d;
            mis_q     <= mis_d;
            bos_q     <= bos_d;
            kcnt_q    <= kcnt_d;
            hs_q      <= hs_d;
            acik_q    <= acik_d;
            hata_q    <= hata_d;
            kilitli_q <= kilitli_d;
            sifre_q   <= sifre_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        adim_d       = adim_q;
        mis_d        = mis_q;
        bos_d        = bos_q;
        kcnt_d       = kcnt_q;
        hs_d         = hs_q;
        acik_d       = acik_q;
        hata_d       = 1'b0;
        kilitli_d    = kilitli_q;
        sifre_d      = sifre_q;
        deneme_bitti = 1'b0;
        basarisiz    = 1'b0;
        yeni_hs      = hs_q + HS_W'(1);

        case (state_q)
            BOSTA: begin
                adim_d = '0;
                if (adim_gecerli) begin
                    // Step 0 is checked against the live input, which is captured on this same edge.
                    sifre_d = kilit_sifreler;
                    mis_d   = adim_hatali(kilit_sifreler, '0, adim_yon, adim_deger);
                    adim_d  = ADIM_W'(1);
                    bos_d   = '0;
                    state_d = GIRIS;
                end
            end
            GIRIS: begin
                if (adim_gecerli) begin
                    adim_d = adim_q + ADIM_W'(1);
                    bos_d  = '0;
                    mis_d  = mis_q | adim_hatali(sifre_q, adim_q, adim_yon, adim_deger);
                    if (adim_q == SON_ADIM) begin
                        deneme_bitti = 1'b1;
                        basarisiz    = mis_d;
                    end
                end else if (bos_q == BOS_SON) begin
                    deneme_bitti = 1'b1;
                    basarisiz    = 1'b1;
                    adim_d       = '0;
                end else begin
                    bos_d = bos_q + BOS_W'(1);
                end
            end
            ACIK: begin
                adim_d = '0;
                if (kilitle) begin
                    state_d = BOSTA;
                    acik_d  = 1'b0;
                end
            end
            KILITLI: begin
                adim_d = '0;
                if (kcnt_q == KS_SON) begin
                    state_d   = BOSTA;
                    kilitli_d = 1'b0;
                    hs_d      = '0;
                    kcnt_d    = '0;
                end else begin
                    kcnt_d = kcnt_q + KS_W'(1);
                end
            end
            default: begin
                state_d = BOSTA;
            end
        endcase

        // The final step count stays visible for one cycle alongside the verdict.
        if (deneme_bitti) begin
            mis_d = 1'b0;
            bos_d = '0;
            if (basarisiz) begin
                hata_d = 1'b1;
                hs_d   = yeni_hs;
                if (yeni_hs == HS_LIM) begin
                    state_d   = KILITLI;
                    kilitli_d = 1'b1;
                    kcnt_d    = '0;
                end else begin
                    state_d = BOSTA;
                end
            end else begin
                state_d = ACIK;
                acik_d  = 1'b1;
                hs_d    = '0;
            end
        end
    end

    assign kilitler_acik = acik_q;
    assign hata          = hata_q;
    assign kilitli       = kilitli_q;
    assign hata_sayisi   = hs_q;
    assign adim_sayaci   = adim_q;

endmodule

// File: tb/tb_coklu_sirali_kilit.sv
// Directed bench for coklu_sirali_kilit with default parameters and combinations 12'h7AA
// (lock0 sag=5 sol=2, lock1 sag=3 sol=6).
module tb_coklu_sirali_kilit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adim_gecerli = 1'b0;
    logic        adim_yon = 1'b0;
    logic [2:0]  adim_deger = '0;
    logic [11:0] kilit_sifreler = 12'h7AA;
    logic        kilitle = 1'b0;
    logic        kilitler_acik;
    logic        hata;
    logic        kilitli;
    logic [1:0]  hata_sayisi;
    logic [2:0]  adim_sayaci;

    int vec = 0;
    int miscmp = 0;

    coklu_sirali_kilit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adim_gecerli   (adim_gecerli),
        .adim_yon       (adim_yon),
        .adim_deger     (adim_deger),
        .kilit_sifreler (kilit_sifreler),
        .kilitle        (kilitle),
        .kilitler_acik  (kilitler_acik),
        .hata           (hata),
        .kilitli        (kilitli),
        .hata_sayisi    (hata_sayisi),
        .adim_sayaci    (adim_sayaci)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tik();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic adim_ver(input logic yon, input logic [2:0] deger);
        adim_gecerli = 1'b1;
        adim_yon     = yon;
        adim_deger   = deger;
        tik();
        adim_gecerli = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tik();
        vec++; if (kilitler_acik !== 1'b0) begin miscmp++; $display("FAIL reset_acik: got %b expected 0", kilitler_acik); end
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL reset_hata: got %b expected 0", hata); end
        vec++; if (kilitli !== 1'b0) begin miscmp++; $display("FAIL reset_kilitli: got %b expected 0", kilitli); end
        vec++; if (hata_sayisi !== 2'd0) begin miscmp++; $display("FAIL reset_hs: got %0d expected 0", hata_sayisi); end
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL reset_adim: got %0d expected 0", adim_sayaci); end
        rst_n = 1'b1;
        tik();
    endtask

    task automatic test_acilis();
        int yon_t[4] = '{0, 1, 0, 1};
        int deg_t[4] = '{5, 2, 3, 6};
        for (int i = 0; i < 4; i++) begin
            adim_ver(1'(yon_t[i]), 3'(deg_t[i]));
            vec++; if (adim_sayaci !== 3'(i + 1)) begin miscmp++; $display("FAIL acilis_adim%0d: got %0d expected %0d", i, adim_sayaci, i + 1); end
            vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL acilis_hata%0d: got %b expected 0", i, hata); end
            vec++; if (kilitler_acik !== (i == 3)) begin miscmp++; $display("FAIL acilis_acik%0d: got %b expected %b", i, kilitler_acik, (i == 3)); end
        end
        tik();
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL acilis_adim_son: got %0d expected 0", adim_sayaci); end
        vec++; if (kilitler_acik !== 1'b1) begin miscmp++; $display("FAIL acilis_acik_tut: got %b expected 1", kilitler_acik); end
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL acilis_hata_son: got %b expected 0", hata); end
    endtask

    task automatic test_kilitle();
        kilitle = 1'b1;
        adim_ver(1'b0, 3'd5);
        kilitle = 1'b0;
        vec++; if (kilitler_acik !== 1'b0) begin miscmp++; $display("FAIL kilitle_acik: got %b expected 0", kilitler_acik); end
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL kilitle_adim: got %0d expected 0", adim_sayaci); end
        tik();
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL kilitle_adim_sonra: got %0d expected 0", adim_sayaci); end
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL kilitle_hata: got %b expected 0", hata); end
    endtask

    task automatic test_yanlis();
        int yon_a[4] = '{0, 1, 0, 1};
        int yon_b[4] = '{1, 1, 0, 1};
        int deg_t[4] = '{5, 3, 3, 6};
        for (int i = 0; i < 4; i++) begin
            adim_ver(1'(yon_a[i]), 3'(deg_t[i]));
            vec++; if (hata !== (i == 3)) begin miscmp++; $display("FAIL yanlis1_hata%0d: got %b expected %b", i, hata, (i == 3)); end
            vec++; if (kilitler_acik !== 1'b0) begin miscmp++; $display("FAIL yanlis1_acik%0d: got %b expected 0", i, kilitler_acik); end
        end
        vec++; if (hata_sayisi !== 2'd1) begin miscmp++; $display("FAIL yanlis1_hs: got %0d expected 1", hata_sayisi); end
        tik();
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL yanlis1_darbe: got %b expected 0", hata); end
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL yanlis1_adim: got %0d expected 0", adim_sayaci); end
        for (int i = 0; i < 4; i++) begin
            adim_ver(1'(yon_b[i]), 3'(deg_t[i]));
            vec++; if (hata !== (i == 3)) begin miscmp++; $display("FAIL yanlis2_hata%0d: got %b expected %b", i, hata, (i == 3)); end
        end
        vec++; if (hata_sayisi !== 2'd2) begin miscmp++; $display("FAIL yanlis2_hs: got %0d expected 2", hata_sayisi); end
        tik();
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL yanlis2_darbe: got %b expected 0", hata); end
    endtask

    task automatic test_kilitleme();
        int sure;
        for (int i = 0; i < 4; i++) adim_ver(1'(i % 2), 3'd0);
        vec++; if (hata !== 1'b1) begin miscmp++; $display("FAIL kilitleme_hata: got %b expected 1", hata); end
        vec++; if (hata_sayisi !== 2'd3) begin miscmp++; $display("FAIL kilitleme_hs: got %0d expected 3", hata_sayisi); end
        vec++; if (kilitli !== 1'b1) begin miscmp++; $display("FAIL kilitleme_basla: got %b expected 1", kilitli); end
        sure = 1;
        for (int i = 0; i < 20; i++) begin
            adim_gecerli = 1'b1;
            adim_yon     = 1'(i % 2);
            adim_deger   = 3'd5;
            kilitle      = 1'b1;
            tik();
            if (kilitli !== 1'b1) break;
            sure++;
            vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL kilitleme_adim%0d: got %0d expected 0", i, adim_sayaci); end
        end
        adim_gecerli = 1'b0;
        kilitle      = 1'b0;
        vec++; if (sure !== 8) begin miscmp++; $display("FAIL kilitleme_sure: got %0d expected 8", sure); end
        vec++; if (kilitli !== 1'b0) begin miscmp++; $display("FAIL kilitleme_bitis: got %b expected 0", kilitli); end
        vec++; if (hata_sayisi !== 2'd0) begin miscmp++; $display("FAIL kilitleme_hs_sifir: got %0d expected 0", hata_sayisi); end
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL kilitleme_adim_son: got %0d expected 0", adim_sayaci); end
        adim_ver(1'b0, 3'd5);
        adim_ver(1'b1, 3'd2);
        adim_ver(1'b0, 3'd3);
        adim_ver(1'b1, 3'd6);
        vec++; if (kilitler_acik !== 1'b1) begin miscmp++; $display("FAIL kilitleme_sonra_acik: got %b expected 1", kilitler_acik); end
        kilitle = 1'b1;
        tik();
        kilitle = 1'b0;
        vec++; if (kilitler_acik !== 1'b0) begin miscmp++; $display("FAIL kilitleme_kapat: got %b expected 0", kilitler_acik); end
    endtask

    task automatic test_zaman_asimi();
        adim_ver(1'b0, 3'd5);
        for (int i = 1; i <= 14; i++) tik();
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL zaman_erken_hata: got %b expected 0", hata); end
        adim_ver(1'b1, 3'd2);
        vec++; if (adim_sayaci !== 3'd2) begin miscmp++; $display("FAIL zaman_adim15: got %0d expected 2", adim_sayaci); end
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL zaman_adim15_hata: got %b expected 0", hata); end
        for (int i = 1; i <= 16; i++) begin
            tik();
            vec++; if (hata !== (i == 16)) begin miscmp++; $display("FAIL zaman_bos%0d: got %b expected %b", i, hata, (i == 16)); end
        end
        vec++; if (hata_sayisi !== 2'd1) begin miscmp++; $display("FAIL zaman_hs: got %0d expected 1", hata_sayisi); end
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL zaman_adim: got %0d expected 0", adim_sayaci); end
        tik();
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL zaman_darbe: got %b expected 0", hata); end
        vec++; if (kilitler_acik !== 1'b0) begin miscmp++; $display("FAIL zaman_acik: got %b expected 0", kilitler_acik); end
    endtask

    task automatic test_reset_ortasi();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) adim_ver(1'(i % 2), 3'd7);
        tik();
        tik();
        vec++; if (kilitli !== 1'b1) begin miscmp++; $display("FAIL rst_kilitli_once: got %b expected 1", kilitli); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if (kilitli !== 1'b0) begin miscmp++; $display("FAIL rst_kilitli_async: got %b expected 0", kilitli); end
        vec++; if (hata_sayisi !== 2'd0) begin miscmp++; $display("FAIL rst_hs_async: got %0d expected 0", hata_sayisi); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        adim_ver(1'b0, 3'd5);
        adim_ver(1'b1, 3'd2);
        vec++; if (adim_sayaci !== 3'd2) begin miscmp++; $display("FAIL rst_adim_once: got %0d expected 2", adim_sayaci); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if (adim_sayaci !== 3'd0) begin miscmp++; $display("FAIL rst_adim_async: got %0d expected 0", adim_sayaci); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        adim_ver(1'b0, 3'd5);
        kilit_sifreler = 12'h000;
        adim_ver(1'b1, 3'd2);
        adim_ver(1'b0, 3'd3);
        adim_ver(1'b1, 3'd6);
        vec++; if (kilitler_acik !== 1'b1) begin miscmp++; $display("FAIL rst_sonra_acik: got %b expected 1", kilitler_acik); end
        vec++; if (hata !== 1'b0) begin miscmp++; $display("FAIL rst_sonra_hata: got %b expected 0", hata); end
        kilit_sifreler = 12'h7AA;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_acilis();
        test_kilitle();
        test_yanlis();
        test_kilitleme();
        test_zaman_asimi();
        test_reset_ortasi();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
